// File: rtl/mag_comparator_serial.sv
// Multi-cycle magnitude comparator: scans a/b MSB-first, DIGIT bits per clock, unsigned or two's-complement.
// Optional MAG_COMPARATOR_EARLY_EXIT_EN ends the scan at the first mismatching digit.
module mag_comparator_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             greater_than,
    output logic             less_than,
    output logic             equal
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CMP, FIN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sa, sb;
    logic [CW-1:0]    cnt;
    logic             decided, dir_gt;
    logic [DIGIT-1:0] da, db;
    logic             mismatch, last, accept;

    assign da       = sa[WIDTH-1 -: DIGIT];
    assign db       = sb[WIDTH-1 -: DIGIT];
    assign mismatch = (da != db);
    assign last     = (cnt == CW'(N - 1));
    assign accept   = start && (state == IDLE || state == FIN);
    assign busy     = (state == CMP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = CMP;
            CMP: begin
                if (last) state_nxt = FIN;
`ifdef MAG_COMPARATOR_EARLY_EXIT_EN
                if (!decided && mismatch) state_nxt = FIN;
`endif
            end
            FIN:     state_nxt = start ? CMP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa           <= '0;
            sb           <= '0;
            cnt          <= '0;
            decided      <= 1'b0;
            dir_gt       <= 1'b0;
            done         <= 1'b0;
            greater_than <= 1'b0;
            less_than    <= 1'b0;
            equal        <= 1'b0;
        end else begin
            done <= (state == FIN);
            if (state == FIN) begin
                greater_than <= decided && dir_gt;
                less_than    <= decided && !dir_gt;
                equal        <= !decided;
            end
            if (accept) begin
                // Flipping the sign bit turns two's-complement order into unsigned order.
                sa      <= a ^ (signed_mode ? MSB : '0);
                sb      <= b ^ (signed_mode ? MSB : '0);
                cnt     <= '0;
                decided <= 1'b0;
                dir_gt  <= 1'b0;
            end else if (state == CMP) begin
                sa  <= sa << DIGIT;
                sb  <= sb << DIGIT;
                cnt <= cnt + CW'(1);
                if (!decided && mismatch) begin
                    decided <= 1'b1;
                    dir_gt  <= (da > db);
                end
            end
        end
    end
endmodule

// File: tb/tb_mag_comparator_serial.sv
// Directed bench for mag_comparator_serial: 16-bit/4-bit-digit vectors plus an exhaustive 4-bit/1-bit sweep.
module tb_mag_comparator_serial;
`ifdef MAG_COMPARATOR_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic clk, rst;
    logic start16, sm16, busy16, done16, gt16, lt16, eq16;
    logic [15:0] a16, b16;
    logic start4, sm4, busy4, done4, gt4, lt4, eq4;
    logic [3:0] a4, b4;

    int checks = 0;
    int errors = 0;
    int lat;

    mag_comparator_serial #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .greater_than(gt16), .less_than(lt16), .equal(eq16));

    mag_comparator_serial #(.WIDTH(4), .DIGIT(1)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .greater_than(gt4), .less_than(lt4), .equal(eq4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // idx = first mismatching digit (0 = MSB digit), -1 for equal operands
    function automatic int exp_lat(input int idx, input int n);
        return (EE && idx >= 0) ? idx + 2 : n + 1;
    endfunction

    task automatic run16(input logic [15:0] av, input logic [15:0] bv, input logic sm,
                         input logic [2:0] exp, input int idx, input string tag);
        logic [2:0] prev;
        @(negedge clk);
        prev = {gt16, lt16, eq16};
        a16 = av; b16 = bv; sm16 = sm; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        a16 = ~av; b16 = ~bv; sm16 = ~sm;
        chk({tag, "_busy"}, busy16, 1);
        chk({tag, "_hold"}, {gt16, lt16, eq16}, prev);
        lat = 0;
        while (!done16 && lat < 40) begin @(posedge clk); #1; lat++; end
        chk({tag, "_lat"}, lat, exp_lat(idx, 4));
        chk({tag, "_flags"}, {gt16, lt16, eq16}, exp);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, done16, 0);
    endtask

    task automatic set4(input int k);
        logic [8:0] v;
        v = k[8:0];
        sm4 = v[8]; a4 = v[7:4]; b4 = v[3:0];
    endtask

    initial begin
        int extra;
        rst = 1'b1;
        start16 = 0; sm16 = 0; a16 = 0; b16 = 0;
        start4 = 0; sm4 = 0; a4 = 0; b4 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst16", {busy16, done16, gt16, lt16, eq16}, 0);
        chk("rst4", {busy4, done4, gt4, lt4, eq4}, 0);
        @(negedge clk); rst = 1'b0;

        run16(16'h1234, 16'h1234, 1'b0, 3'b001, -1, "eq_1234");
        run16(16'h8000, 16'h7FFF, 1'b0, 3'b100, 0, "uns_8000");
        run16(16'h8000, 16'h7FFF, 1'b1, 3'b010, 0, "sgn_8000");
        run16(16'h00F1, 16'h00F2, 1'b0, 3'b010, 3, "uns_00f1");
        run16(16'hFFFF, 16'h0001, 1'b1, 3'b010, 0, "sgn_m1");
        run16(16'h0001, 16'hFFFF, 1'b1, 3'b100, 0, "sgn_p1");

        // second start during CMP must be ignored
        @(negedge clk);
        a16 = 16'h0005; b16 = 16'h0003; sm16 = 0; start16 = 1'b1;
        @(posedge clk); #1; start16 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        a16 = 16'h0000; b16 = 16'hFFFF; start16 = 1'b1;
        @(posedge clk); #1; start16 = 1'b0;
        lat = 3;
        while (!done16 && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("ign_lat", lat, 5);
        chk("ign_flags", {gt16, lt16, eq16}, 3'b100);
        extra = 0;
        repeat (8) begin @(posedge clk); #1; if (done16) extra++; end
        chk("ign_nodone", extra, 0);
        chk("ign_hold", {busy16, gt16, lt16, eq16}, 4'b0100);

        // reset mid-compare
        @(negedge clk);
        a16 = 16'h1234; b16 = 16'h1235; start16 = 1'b1;
        @(posedge clk); #1; start16 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst", {busy16, done16, gt16, lt16, eq16}, 0);
        extra = 0;
        repeat (3) begin @(posedge clk); #1; if (done16) extra++; end
        chk("midrst_nodone", extra, 0);
        @(negedge clk); rst = 1'b0;
        run16(16'h1234, 16'h1235, 1'b0, 3'b010, 3, "post_rst");

        // exhaustive 4-bit sweep, start held high so every FIN accepts the next pair
        @(negedge clk);
        set4(0); start4 = 1'b1;
        @(posedge clk); #1;
        set4(1);
        for (int j = 0; j < 512; j++) begin
            int va, vb, idx;
            logic [3:0] ma, mb;
            logic [2:0] exp;
            logic [8:0] v;
            v = j[8:0];
            ma = v[7:4] ^ (v[8] ? 4'h8 : 4'h0);
            mb = v[3:0] ^ (v[8] ? 4'h8 : 4'h0);
            va = (v[8] && v[7]) ? int'(v[7:4]) - 16 : int'(v[7:4]);
            vb = (v[8] && v[3]) ? int'(v[3:0]) - 16 : int'(v[3:0]);
            exp = (va > vb) ? 3'b100 : (va < vb) ? 3'b010 : 3'b001;
            idx = -1;
            for (int i = 3; i >= 0; i--)
                if (idx < 0 && ma[i] != mb[i]) idx = 3 - i;
            lat = 0;
            do begin @(posedge clk); #1; lat++; end while (!done4 && lat < 20);
            chk($sformatf("ex_lat_%0d", j), lat, exp_lat(idx, 4));
            chk($sformatf("ex_flags_%0d", j), {gt4, lt4, eq4}, exp);
            if (j + 2 < 512) set4(j + 2);
            else start4 = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
